ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  PS/2 host-to-device transmitter: sends one command byte (e.g. 0xF4 enable reporting) to the mouse.
//  Sequence: inhibit the line, request-to-send, serialise 8 data bits + odd parity + stop, check device ACK.
//  Shares the open-drain PS/2 lines with the mouse receiver; busy gates that receiver while a frame is driven.
// PARAMETERS
//  INHIBIT_CYCLES  12_000     clock_100Mhz cycles PS/2 clock is held low before start (120 us)
//  TIMEOUT_CYCLES  2_000_000  max cycles between device-clock falling edges, or waiting for line idle (20 ms)
//  SYNC_STAGES     2          flip-flop stages on ps2_clk_in / ps2_data_in
// PORTS
//  clock_100Mhz  in   1  system clock, 100 MHz
//  reset         in   1  synchronous, active-high reset
//  tx_valid      in   1  command byte request
//  tx_data       in   8  command byte
//  tx_ready      out  1  high only in IDLE; byte accepted when tx_valid && tx_ready
//  ps2_clk_in    in   1  PS/2 clock pin (async)
//  ps2_data_in   in   1  PS/2 data pin (async)
//  ps2_clk_oe    out  1  1 = drive PS/2 clock low, 0 = release
//  ps2_data_oe   out  1  1 = drive PS/2 data low, 0 = release
//  busy          out  1  high in every state except IDLE
//  tx_done       out  1  1-cycle pulse: frame sent and ACK seen
//  tx_ack_err    out  1  1-cycle pulse: data high at ACK sample
//  tx_timeout    out  1  1-cycle pulse: device silent for TIMEOUT_CYCLES
// BEHAVIOUR
//  Clock and reset: one clock (clock_100Mhz); synchronous active-high reset.
//  Reset values: state IDLE; tx_ready=1; busy=0; ps2_clk_oe=0; ps2_data_oe=0; all pulses 0.
//  Reset mid-frame: lines released on the next edge; no pulse is emitted.
//  Input sync: both pins pass through SYNC_STAGES flops. fall = synced clk was 1 last cycle and is 0 now.
//  Accept: on accept, latch shreg = {~^tx_data, tx_data} (odd parity), bitcnt=0, go to INHIBIT.
//  INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles; data_oe=1 in the last cycle; then go to REQ.
//  REQ: clk_oe=0, data_oe=1 (start bit).
//  REQ/DATA, on each fall: data_oe = ~shreg[0]; shift right; bitcnt++.
//    Falls 1-8: data bits, LSB first. Fall 9: parity bit.
//  STOP: fall 10 sets data_oe=0 (stop bit = 1); go to ACK.
//  ACK: on fall 11, sample synced data.
//    0 -> WAIT_IDLE.
//    1 -> pulse tx_ack_err, go to IDLE.
//  WAIT_IDLE: wait until synced clk and data are both 1; pulse tx_done; go to IDLE.
//  Timeout: a counter clears on state entry and on every fall; it runs in REQ, DATA, STOP, ACK and WAIT_IDLE.
//    On reaching TIMEOUT_CYCLES: both oe=0, pulse tx_timeout, go to IDLE.
//  Pulses are mutually exclusive and each is exactly one cycle; tx_ready rises the cycle after a pulse.
//  tx_valid while busy is ignored; no queueing.
//  Falls seen during INHIBIT are ignored.
//  Latency from accept to first driven edge is 1 cycle.
// STRUCTURE
//  Shared header ps2_defs.vh:
//    state encodings IDLE/INHIBIT/REQ/DATA/STOP/ACK/WAIT_IDLE;
//    command constants CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, CMD_SET_RATE=8'hF3;
//    response constant RSP_ACK=8'hFA.
//  Sub-module ps2_line_sync: SYNC_STAGES synchroniser for clk and data, plus the fall strobe.
//    To be reused by the receiver.
//  Top level: FSM, 9-bit shift register, 4-bit bitcnt, 14-bit inhibit counter, 21-bit timeout counter.
// TESTING
//  Bench device model clocks at ~12.5 kHz, samples data on rising edges and ACKs.
//  1. Send 0xF4 -> device sees start 0; bits 0,0,1,0,1,1,1,1; parity 0; stop 1.
//     Required: tx_done once; clk_oe low >= 12_000 cycles first.
//  2. Send 0xFF -> parity bit 1.
//     Send 0x00 -> parity bit 1.
//     Both end with tx_done.
//  3. Device gives no ACK (data high at fall 11) -> tx_ack_err pulse; oe=0; tx_ready=1.
//  4. Device never clocks after REQ -> tx_timeout exactly TIMEOUT_CYCLES after REQ entry; lines released.
//  5. reset asserted after fall 4 -> both oe=0 next edge; no pulses.
//     A new 0xF4 afterwards completes normally.
//  6. tx_valid with 0xAA held during a frame -> ignored.
//     Device receives only the first byte; tx_ready=0 throughout.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, command/response bytes, parity helper.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StData,
        StStop,
        StAck,
        StWaitIdle
    } ps2_tx_state_e;

    localparam logic [7:0] CmdReset   = 8'hFF;
    localparam logic [7:0] CmdEnable  = 8'hF4;
    localparam logic [7:0] CmdSetRate = 8'hF3;
    localparam logic [7:0] RspAck     = 8'hFA;

    // Parity bit that makes the 9-bit {parity, data} word contain an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchroniser for the PS/2 clock and data pins plus a one-cycle falling-edge strobe on clock.
// Shared by the host transmitter and the mouse receiver; SyncStages must be at least 2.
module ps2_line_sync #(
    parameter int unsigned SyncStages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_s_o,
    output logic data_s_o,
    output logic clk_fall_o
);

    logic [SyncStages-1:0] clk_sync_q;
    logic [SyncStages-1:0] data_sync_q;
    logic                  clk_prev_q;

    // Reset to the idle (released, pulled-up) level so no false fall appears after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SyncStages-2:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[SyncStages-2:0], ps2_data_i};
            clk_prev_q  <= clk_sync_q[SyncStages-1];
        end
    end

    assign clk_s_o    = clk_sync_q[SyncStages-1];
    assign data_s_o   = data_sync_q[SyncStages-1];
    assign clk_fall_o = clk_prev_q & ~clk_sync_q[SyncStages-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data + odd parity + stop,
// then device ACK check. Drives the open-drain lines through active-high output enables.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 12_000,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clock_100Mhz,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_ack_err,
    output logic       tx_timeout
);

    localparam int unsigned InhW = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
    localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES);

    ps2_tx_state_e   state_q, state_d;
    logic [8:0]      shreg_q, shreg_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
    logic [ToW-1:0]  to_cnt_q, to_cnt_d;
    logic            clk_oe_q, clk_oe_d;
    logic            data_oe_q, data_oe_d;
    logic            done, ack_err, timeout, to_run;
    logic            clk_s, data_s, fall;

    ps2_line_sync #(
        .SyncStages(SYNC_STAGES)
    ) u_line_sync (
        .clk_i      (clock_100Mhz),
        .rst_i      (reset),
        .ps2_clk_i  (ps2_clk_in),
        .ps2_data_i (ps2_data_in),
        .clk_s_o    (clk_s),
        .data_s_o   (data_s),
        .clk_fall_o (fall)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        inh_cnt_d = inh_cnt_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done      = 1'b0;
        ack_err   = 1'b0;
        timeout   = 1'b0;
        to_run    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tx_valid) begin
                    state_d   = StInhibit;
                    shreg_d   = {odd_parity(tx_data), tx_data};
                    bitcnt_d  = 4'd0;
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = (INHIBIT_CYCLES == 1);
                end
            end
            StInhibit: begin
                if (inh_cnt_q == InhLast) begin
                    state_d   = StReq;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                end else begin
                    inh_cnt_d = inh_cnt_q + InhW'(1);
                    // Data goes low in the final inhibit cycle, ahead of the clock release.
                    data_oe_d = (inh_cnt_q + InhW'(1) == InhLast);
                end
            end
            StReq, StData: begin
                to_run = 1'b1;
                if (fall) begin
                    data_oe_d = ~shreg_q[0];
                    shreg_d   = {1'b0, shreg_q[8:1]};
                    bitcnt_d  = bitcnt_q + 4'd1;
                    state_d   = (bitcnt_q == 4'd8) ? StStop : StData;
                end
            end
            StStop: begin
                to_run = 1'b1;
                if (fall) begin
                    data_oe_d = 1'b0;
                    state_d   = StAck;
                end
            end
            StAck: begin
                to_run = 1'b1;
                if (fall) begin
                    if (!data_s) begin
                        state_d = StWaitIdle;
                    end else begin
                        ack_err = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StWaitIdle: begin
                to_run = 1'b1;
                if (clk_s && data_s) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A silent device overrides whatever the state logic decided this cycle.
        if (to_run && to_cnt_q == ToLast) begin
            state_d   = StIdle;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            timeout   = 1'b1;
            done      = 1'b0;
            ack_err   = 1'b0;
        end

        if (state_d != state_q || fall || !to_run) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + ToW'(1);
        end
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
        end
    end

    assign tx_ready    = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = done & ~reset;
    assign tx_ack_err  = ack_err & ~reset;
    assign tx_timeout  = timeout & ~reset;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with an open-drain PS/2 device model (time-scaled parameters).
module tb_ps2_host_tx;

    localparam int unsigned InhCyc = 120;
    localparam int unsigned ToCyc  = 2000;
    localparam int unsigned Half   = 40;

    localparam int EvDone = 1;
    localparam int EvAckErr = 2;
    localparam int EvTimeout = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_ack_err, tx_timeout;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_line, ps2_data_line;

    always #5 clk = ~clk;

    assign ps2_clk_line  = !(ps2_clk_oe || dev_clk_low);
    assign ps2_data_line = !(ps2_data_oe || dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(InhCyc),
        .TIMEOUT_CYCLES(ToCyc),
        .SYNC_STAGES   (2)
    ) dut (
        .clock_100Mhz(clk),
        .reset       (reset),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_ack_err  (tx_ack_err),
        .tx_timeout  (tx_timeout)
    );

    int errors = 0;
    int checks = 0;
    int exp_evt[$];
    int exp_frame[$];
    int dev_mode = 0;  // 0 ack, 1 no ack, 2 silent, 3 stop after fall 4
    logic abort_hit = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pulses against the event scoreboard, inhibit shape, timeout latency.
    int   cyc = 0;
    int   req_cyc = 0;
    int   inh_run = 0;
    logic prev_data_oe = 1'b0;
    initial begin
        forever begin
            int n, code;
            @(negedge clk);
            cyc++;
            if (ps2_clk_oe) begin
                if (inh_run == 0) check("data_released_at_inhibit_start", ps2_data_oe, 0);
                inh_run++;
            end else begin
                if (inh_run > 0) begin
                    check("inhibit_length", inh_run, InhCyc);
                    check("data_low_in_last_inhibit_cycle", prev_data_oe, 1);
                    req_cyc = cyc;
                end
                inh_run = 0;
            end
            prev_data_oe = ps2_data_oe;
            n = int'(tx_done) + int'(tx_ack_err) + int'(tx_timeout);
            if (n > 0) begin
                code = tx_done ? EvDone : (tx_ack_err ? EvAckErr : EvTimeout);
                check("pulse_exclusive", n, 1);
                if (exp_evt.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got kind %0d, expected none", code);
                end else begin
                    int e;
                    e = exp_evt.pop_front();
                    check("pulse_kind", code, e);
                    if (e == EvTimeout) check("timeout_latency", cyc - req_cyc, ToCyc);
                end
            end
        end
    end

    // Device model: clocks the frame, samples data after each rising edge, compares the frame.
    initial begin
        forever begin
            @(negedge clk);
            if (busy && ps2_clk_line && !ps2_data_line) begin
                int mode;
                logic [10:0] f;
                mode = dev_mode;
                f = '0;
                f[0] = ps2_data_line;
                if (mode != 2) begin
                    repeat (Half) @(negedge clk);
                    for (int i = 1; i <= 10; i++) begin
                        if (mode == 3 && i == 5) break;
                        dev_clk_low = 1'b1;
                        repeat (Half) @(negedge clk);
                        dev_clk_low = 1'b0;
                        repeat (Half / 2) @(negedge clk);
                        f[i] = ps2_data_line;
                        repeat (Half / 2) @(negedge clk);
                    end
                    if (mode == 3) begin
                        abort_hit = 1'b1;
                    end else begin
                        if (mode == 0) dev_data_low = 1'b1;
                        repeat (4) @(negedge clk);
                        dev_clk_low = 1'b1;
                        repeat (Half) @(negedge clk);
                        dev_clk_low = 1'b0;
                        repeat (4) @(negedge clk);
                        dev_data_low = 1'b0;
                        if (exp_frame.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_frame: got 0x%0h, expected none", f);
                        end else begin
                            check("device_frame", int'(f), exp_frame.pop_front());
                        end
                    end
                end
                while (busy) @(negedge clk);
            end
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (!tx_ready && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!tx_ready) begin
            checks++;
            errors++;
            $display("FAIL %s: tx_ready stuck at 0, expected 1 within 20000 cycles", name);
        end
    endtask

    // Issue one byte; evt/frame < 0 means nothing is expected on that channel.
    task automatic send(input logic [7:0] b, input int evt, input int frame, input bit hold);
        wait_ready("ready_before_send");
        if (evt > 0) exp_evt.push_back(evt);
        if (frame >= 0) exp_frame.push_back(frame);
        tx_valid = 1'b1;
        tx_data  = b;
        @(posedge clk);
        #1;
        check("accept_clk_oe_next_cycle", ps2_clk_oe, 1);
        check("busy_after_accept", busy, 1);
        if (hold) begin
            tx_data = 8'hAA;
        end else begin
            tx_valid = 1'b0;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx_ready", tx_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_clk_oe", ps2_clk_oe, 0);
        check("reset_data_oe", ps2_data_oe, 0);
        check("reset_pulses", {tx_done, tx_ack_err, tx_timeout}, 0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // 0xF4: bits 0,0,1,0,1,1,1,1, parity 0 -> frame {stop,par,data,start} = 0x5E8
        dev_mode = 0;
        send(8'hF4, EvDone, 11'h5E8, 1'b0);
        wait_ready("f4_done");
        // 0xFF and 0x00 both carry parity 1
        send(8'hFF, EvDone, 11'h7FE, 1'b0);
        wait_ready("ff_done");
        send(8'h00, EvDone, 11'h600, 1'b0);
        wait_ready("00_done");

        // No ACK: frame still received, then ack error
        dev_mode = 1;
        send(8'hF3, EvAckErr, 11'h7E6, 1'b0);
        wait_ready("noack_done");
        check("noack_clk_oe", ps2_clk_oe, 0);
        check("noack_data_oe", ps2_data_oe, 0);
        check("noack_ready", tx_ready, 1);

        // Silent device: timeout, lines released
        dev_mode = 2;
        send(8'h55, EvTimeout, -1, 1'b0);
        wait_ready("timeout_done");
        check("timeout_clk_line", ps2_clk_line, 1);
        check("timeout_data_line", ps2_data_line, 1);

        // Reset after fall 4
        dev_mode = 3;
        send(8'hF4, -1, -1, 1'b0);
        begin
            int n = 0;
            while (!abort_hit && n < 20000) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("abort_point_reached", abort_hit, 1);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_clk_oe", ps2_clk_oe, 0);
        check("midreset_data_oe", ps2_data_oe, 0);
        check("midreset_busy", busy, 0);
        reset = 1'b0;
        abort_hit = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        dev_mode = 0;
        send(8'hF4, EvDone, 11'h5E8, 1'b0);
        wait_ready("after_reset_done");

        // 0x01 (parity 0) with tx_valid held at 0xAA for the whole frame
        send(8'h01, EvDone, 11'h402, 1'b1);
        begin
            int   n = 0;
            logic ready_seen = 1'b0;
            while (!(tx_done || tx_ack_err || tx_timeout) && n < 20000) begin
                if (tx_ready) ready_seen = 1'b1;
                @(posedge clk);
                #1;
                n++;
            end
            tx_valid = 1'b0;
            check("ready_low_while_busy", ready_seen, 0);
        end
        wait_ready("hold_done");
        repeat (200) @(posedge clk);
        #1;
        check("held_byte_ignored", busy, 0);
        check("events_outstanding", exp_evt.size(), 0);
        check("frames_outstanding", exp_frame.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
